// File: rtl/shift_sequencer.sv
// Multi-pass sequencer around a 16-bit barrel shifter whose per-pass distance is limited to 15.
// A request is walked through up to five shifter passes, and the result is held until it is consumed.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InA,
  input  logic [AMT_W-1:0] InAmount,
  input  logic             InChoice,
  output logic [WIDTH-1:0] ShA,
  output logic [3:0]       ShShift,
  output logic             ShChoice,
  input  logic [WIDTH-1:0] ShOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [2:0]       PassCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] work_r, work_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic             dir_r, dir_s;
  logic [2:0]       pass_r, pass_s;
  logic [3:0]       step_s;
  logic [AMT_W-1:0] step_ext_s;
  logic             in_ready_s;
  logic [3:0]       sh_shift_s;

  // Per-pass distance: the shifter accepts at most 15 per pass.
  always_comb begin
    step_s = 4'd0;
    if (rem_r > AMT_W'(15)) begin
      step_s = 4'd15;
    end else begin
      step_s = rem_r[3:0];
    end
    step_ext_s = AMT_W'(step_s);
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_s    = state_r;
    work_s     = work_r;
    rem_s      = rem_r;
    dir_s      = dir_r;
    pass_s     = pass_r;
    in_ready_s = 1'b0;
    sh_shift_s = 4'd0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (InValid) begin
          work_s = InA;
          rem_s  = InAmount;
          dir_s  = InChoice;
          pass_s = 3'd0;
          if (InAmount != {AMT_W{1'b0}}) begin
            state_s = SHIFT;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sh_shift_s = step_s;
        work_s     = ShOut;
        rem_s      = rem_r - step_ext_s;
        pass_s     = pass_r + 3'd1;
        // No early exit on a zero work value, so latency depends only on the amount.
        if (rem_r == step_ext_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= {WIDTH{1'b0}};
      rem_r   <= {AMT_W{1'b0}};
      dir_r   <= 1'b0;
      pass_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      rem_r   <= rem_s;
      dir_r   <= dir_s;
      pass_r  <= pass_s;
    end
  end

  // InReady is gated by rst_n so that it drops as soon as reset is asserted.
  assign InReady   = in_ready_s & rst_n;
  assign ShA       = work_r;
  assign ShShift   = sh_shift_s;
  assign ShChoice  = dir_r;
  assign OutValid  = (state_r == DONE);
  assign OutData   = work_r;
  assign PassCount = pass_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer, with a behavioural barrel shifter attached to the Sh* ports.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic [15:0] InA;
  logic [5:0]  InAmount;
  logic        InChoice;
  logic [15:0] ShA;
  logic [3:0]  ShShift;
  logic        ShChoice;
  logic [15:0] ShOut;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] OutData;
  logic [2:0]  PassCount;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  pc;
    int          lat;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] sh_trace[$];
  logic [3:0] exp_trace[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         seen_valid = 1'b1;

  shift_sequencer #(.WIDTH(16), .AMT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InAmount(InAmount), .InChoice(InChoice),
    .ShA(ShA), .ShShift(ShShift), .ShChoice(ShChoice), .ShOut(ShOut),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .PassCount(PassCount)
  );

  assign ShOut = ShChoice ? (ShA << ShShift) : (ShA >> ShShift);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_shift(input logic [15:0] a, input int amt, input logic ch);
    if (amt >= 16) return 16'h0000;
    return ch ? (a << amt) : (a >> amt);
  endfunction

  // Observation at the falling edge: acceptance, latency, result consumption, shifter trace.
  always @(negedge clk) begin
    if (rst_n) begin
      if (InValid && InReady) begin
        exp_t e;
        e.data = model_shift(InA, int'(InAmount), InChoice);
        e.pc   = 3'((int'(InAmount) + 14) / 15);
        e.lat  = (int'(InAmount) + 14) / 15;
        expq.push_back(e);
        acc_cyc    = cyc + 1;
        seen_valid = 1'b0;
      end
      if (!InReady && !OutValid) sh_trace.push_back(ShShift);
      if (OutValid && expq.size() == 0) begin
        chk("stray_valid", 32'(OutValid), 32'd0);
      end else if (OutValid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          chk("latency", 32'(cyc - acc_cyc), 32'(expq[0].lat));
        end
        if (OutReady) begin
          exp_t e;
          e = expq.pop_front();
          chk("outdata", 32'(OutData), 32'(e.data));
          chk("passcount", 32'(PassCount), 32'(e.pc));
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [5:0] amt, input logic ch);
    int n = 0;
    int r;
    sh_trace.delete();
    exp_trace.delete();
    r = int'(amt);
    while (r > 0) begin
      exp_trace.push_back((r > 15) ? 4'd15 : 4'(r));
      r = r - ((r > 15) ? 15 : r);
    end
    InValid = 1'b1; InA = a; InAmount = amt; InChoice = ch;
    while (!InReady && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    InValid = 1'b0;
    InA = 16'($urandom); InAmount = 6'($urandom); InChoice = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || !InReady) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_trace(input string tag);
    chk({tag, "_passes"}, 32'(sh_trace.size()), 32'(exp_trace.size()));
    for (int i = 0; i < sh_trace.size() && i < exp_trace.size(); i++)
      chk({tag, "_shshift"}, 32'(sh_trace[i]), 32'(exp_trace[i]));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [5:0] amt, input logic ch);
    send(a, amt, ch);
    wait_idle();
    check_trace(tag);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; InValid = 1'b0; InA = 16'h0000; InAmount = 6'd0; InChoice = 1'b0; OutReady = 1'b1;
    #1;
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_outdata", 32'(OutData), 32'd0);
    chk("rst_passcount", 32'(PassCount), 32'd0);
    chk("rst_shshift", 32'(ShShift), 32'd0);
    #20 rst_n = 1'b1;
    #1 chk("rel_inready", 32'(InReady), 32'd1);
    @(posedge clk); #1;

    run_op("left3", 16'hB252, 6'd3, 1'b1);
    run_op("right15", 16'h8000, 6'd15, 1'b0);
    run_op("right20", 16'hFFFF, 6'd20, 1'b0);
    run_op("zero_amt", 16'h1234, 6'd0, 1'b0);
    run_op("left16", 16'h0001, 6'd16, 1'b1);
    run_op("right30", 16'hFFFF, 6'd30, 1'b0);

    // Held result under back-pressure with the longest request.
    OutReady = 1'b0;
    send(16'hABCD, 6'd63, 1'b1);
    n = 0;
    while (!OutValid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_valid", 32'(OutValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_inready", 32'(InReady), 32'd0);
      chk("hold_outdata", 32'(OutData), 32'd0);
      chk("hold_passcount", 32'(PassCount), 32'd5);
      chk("hold_outvalid", 32'(OutValid), 32'd1);
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    chk("release_inready", 32'(InReady), 32'd1);
    chk("release_outvalid", 32'(OutValid), 32'd0);
    chk("release_empty", 32'(expq.size()), 32'd0);

    for (int i = 0; i < 16; i++)
      run_op("random", 16'($urandom), 6'($urandom_range(0, 63)), 1'($urandom));

    // Abort a 40-bit shift during its second pass.
    send(16'hFFFF, 6'd40, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("abort_outvalid", 32'(OutValid), 32'd0);
    chk("abort_inready", 32'(InReady), 32'd0);
    chk("abort_sha", 32'(ShA), 32'd0);
    chk("abort_shshift", 32'(ShShift), 32'd0);
    chk("abort_shchoice", 32'(ShChoice), 32'd0);
    chk("abort_passcount", 32'(PassCount), 32'd0);
    chk("abort_outdata", 32'(OutData), 32'd0);
    #10 rst_n = 1'b1;
    #1 chk("abort_rel_inready", 32'(InReady), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(OutValid), 32'd0);
    end

    run_op("post_abort", 16'h00F0, 6'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 16, data width; it matches the downstream barrel shifter.
REQ-002 SHALL have parameter AMT_W, 6, request shift-amount width (0..63).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InValid  input  1  request valid.
REQ-006 SHALL have port InReady  output  1  request accepted when InValid&&InReady at a clk edge.
REQ-007 SHALL have port InA  input  WIDTH  operand.
REQ-008 SHALL have port InAmount  input  AMT_W  total shift distance.
REQ-009 SHALL have port InChoice  input  1  direction: 0 right shift, 1 left shift.
REQ-010 SHALL have port ShA  output  WIDTH  operand driven to barrel shifter A input.
REQ-011 SHALL have port ShShift  output  4  per-pass distance driven to the shifter's Shift input.
REQ-012 SHALL have port ShChoice  output  1  direction driven to the shifter's ShiftChoice input.
REQ-013 SHALL have port ShOut  input  WIDTH  combinational result returned from the shifter's out port.
REQ-014 SHALL have port OutValid  output  1  result valid.
REQ-015 SHALL have port OutReady  input  1  result consumed when OutValid&&OutReady at a clk edge.
REQ-016 SHALL have port OutData  output  WIDTH  final shifted value.
REQ-017 SHALL have port PassCount  output  3  number of shifter passes used for the current result.

Function
REQ-018 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-019 IDLE SHALL drive InReady=1 and ShShift=0; all other states SHALL drive InReady=0.
REQ-020 On acceptance, SHALL latch InA into the work register, InAmount into the remaining counter and InChoice into the direction register, and clear PassCount.
REQ-021 On acceptance, the next state SHALL be SHIFT if InAmount!=0, else DONE.
REQ-022 SHIFT SHALL drive ShA=work, ShChoice=direction and ShShift=min(remaining,15).
REQ-023 Each SHIFT cycle SHALL load work<=ShOut, subtract the step from remaining, and increment PassCount.
REQ-024 SHIFT SHALL go to DONE on the edge where remaining reaches 0; passes P=ceil(amount/15), max 5.
REQ-025 There SHALL be no early exit when work becomes 0; latency is deterministic.
REQ-026 Latency: if acceptance occurs at edge E0, OutValid SHALL be high after edge E0+P (P=0 gives valid right after E0).
REQ-027 The shift SHALL be logical, with zero fill in both directions; amounts >=16 SHALL yield 0.
REQ-028 DONE SHALL hold OutValid=1 with OutData=work and PassCount stable until OutReady=1, then go to IDLE.
REQ-029 No request SHALL be accepted in the cycle the result is consumed; the earliest new acceptance is the next edge.
REQ-030 Input changes after acceptance SHALL NOT affect the operation in flight.
REQ-031 OutReady SHALL be ignored outside DONE; InValid SHALL be ignored outside IDLE.

Reset
REQ-032 Asserting rst_n low SHALL immediately force state IDLE, work=0, remaining=0, direction=0, PassCount=0, OutValid=0, OutData=0, ShA=0, ShShift=0 and ShChoice=0.
REQ-033 While rst_n is low, InReady SHALL be 0; after release, InReady SHALL be 1.
REQ-034 A reset mid-SHIFT or mid-DONE SHALL discard the operation; no stale OutValid SHALL appear after release.

Verification
REQ-035 InA=16'hB252, InAmount=3, InChoice=1 -> OutData=16'h9290, PassCount=1, OutValid after E0+1.
REQ-036 InA=16'h8000, InAmount=15, InChoice=0 -> OutData=16'h0001, PassCount=1; ShShift=15 during the pass.
REQ-037 InA=16'hFFFF, InAmount=20, InChoice=0 -> ShShift=15 then 5, OutData=16'h0000, PassCount=2, OutValid after E0+2.
REQ-038 InA=16'h1234, InAmount=0 -> OutData=16'h1234, PassCount=0, OutValid after E0; ShShift stays 0.
REQ-039 InAmount=63, InChoice=1, OutReady held low 5 cycles -> PassCount=5, OutData=0 stable, InReady=0 throughout; IDLE one edge after OutReady=1.
REQ-040 rst_n pulsed low during the second pass of a 40-bit shift -> outputs reset immediately, InReady=1 after release, OutValid never asserts for the aborted request.
